// File: rtl/memory_dcache.sv
// memory_dcache: memory stage of the pipelined data cache.
//   Owns the two-way data arrays, serves hits at one per cycle and runs the
//   write-back / refill sequence against physical memory on misses. Metadata
//   (valid/dirty/tag/LRU) lives in the execute stage; this block only drives
//   the update strobes back to it, coincident with resp.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_*                  request block from the execute (tag-compare) stage
//   stall                 upstream must hold its block (WB/FILL/MRESP)
//   resp, rdata           completion pulse and load data
//   upd_*                 metadata update strobes toward the execute stage
//   pmem_*                line-granular physical memory handshake
//   hit_count, miss_count performance counters
// Configuration:
//   DCACHE_PERF_CNT_EN    when defined, builds saturating hit/miss counters;
//                         otherwise both counters are tied to zero.
module memory_dcache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_line   = 8 * 2**s_offset
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [31:0]         in_addr,
  input  logic                in_read,
  input  logic                in_write,
  input  logic [31:0]         in_wdata,
  input  logic [3:0]          in_mbe,
  input  logic                in_hit,
  input  logic                in_way,
  input  logic                in_lru,
  input  logic                in_dirty,
  input  logic [s_tag-1:0]    in_victim_tag,
  output logic                stall,
  output logic                resp,
  output logic [31:0]         rdata,
  output logic [s_index-1:0]  upd_index,
  output logic                upd_way,
  output logic                upd_lru_en,
  output logic                upd_lru,
  output logic                upd_line_en,
  output logic [s_tag-1:0]    upd_tag,
  output logic                upd_dirty,
  output logic                upd_dirty_set,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [31:0]         pmem_address,
  output logic [s_line-1:0]   pmem_wdata,
  input  logic [s_line-1:0]   pmem_rdata,
  input  logic                pmem_resp,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int num_sets  = 2**s_index;
  localparam int num_words = 2**(s_offset - 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIT   = 3'd1,
    ST_WB    = 3'd2,
    ST_FILL  = 3'd3,
    ST_MRESP = 3'd4
  } state_e;

  state_e state_r, state_nxt_s;

  // Captured request block
  logic               blk_valid_r;
  logic [31:0]        addr_r;
  logic               write_r;
  logic [31:0]        wdata_r;
  logic [3:0]         mbe_r;
  logic               way_r;
  logic               lru_r;
  logic [s_tag-1:0]   victim_tag_r;

  logic [s_line-1:0]  data_r [2][num_sets];

  logic               accept_s;
  logic               acc_way_s;
  logic [s_index-1:0] idx_s;
  logic [s_tag-1:0]   tag_s;
  logic [s_offset-3:0] word_s;
  logic [s_line-1:0]  cur_line_s;
  logic [s_line-1:0]  merged_line_s;
  logic [31:0]        cur_word_s;
  logic               fill_we_s;
  logic               merge_we_s;
  logic               unused_s;

  assign stall     = (state_r == ST_WB) || (state_r == ST_FILL) || (state_r == ST_MRESP);
  assign accept_s  = in_valid && !stall;
  assign idx_s     = addr_r[s_offset +: s_index];
  assign tag_s     = addr_r[s_offset + s_index +: s_tag];
  assign word_s    = addr_r[2 +: s_offset - 2];
  // Hits address the hit way; every miss-path state addresses the victim way.
  assign acc_way_s = (state_r == ST_HIT) ? way_r : lru_r;
  assign cur_line_s = data_r[acc_way_s][idx_s];
  assign fill_we_s  = (state_r == ST_FILL) && pmem_resp;
  assign merge_we_s = resp && write_r;
  // Read type is implied by !write; byte offset is below word granularity.
  assign unused_s   = ^{in_read, addr_r[1:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_HIT: begin
        if (accept_s) begin
          if (in_hit)        state_nxt_s = ST_HIT;
          else if (in_dirty) state_nxt_s = ST_WB;
          else               state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WB:    state_nxt_s = pmem_resp ? ST_FILL : ST_WB;
      ST_FILL:  state_nxt_s = pmem_resp ? ST_MRESP : ST_FILL;
      ST_MRESP: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Request block capture; the block is consumed by HIT or MRESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_valid_r  <= 1'b0;
      addr_r       <= 32'd0;
      write_r      <= 1'b0;
      wdata_r      <= 32'd0;
      mbe_r        <= 4'd0;
      way_r        <= 1'b0;
      lru_r        <= 1'b0;
      victim_tag_r <= '0;
    end else if (accept_s) begin
      blk_valid_r  <= 1'b1;
      addr_r       <= in_addr;
      write_r      <= in_write;
      wdata_r      <= in_wdata;
      mbe_r        <= in_mbe;
      way_r        <= in_way;
      lru_r        <= in_lru;
      victim_tag_r <= in_victim_tag;
    end else if (resp) begin
      blk_valid_r  <= 1'b0;
    end
  end

  // Word select and store-byte merge on the addressed line
  always_comb begin
    merged_line_s = cur_line_s;
    cur_word_s    = 32'd0;
    for (int w = 0; w < num_words; w++) begin
      if (int'(word_s) == w) begin
        cur_word_s = cur_line_s[w*32 +: 32];
        for (int b = 0; b < 4; b++) begin
          if (mbe_r[b]) merged_line_s[w*32 + b*8 +: 8] = wdata_r[b*8 +: 8];
          else          merged_line_s[w*32 + b*8 +: 8] = cur_line_s[w*32 + b*8 +: 8];
        end
      end else begin
        merged_line_s[w*32 +: 32] = cur_line_s[w*32 +: 32];
      end
    end
  end

  // Data arrays (not reset): refill on pmem_resp, store merge on HIT/MRESP
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      data_r[lru_r][idx_s] <= pmem_rdata;
    end else if (merge_we_s) begin
      data_r[acc_way_s][idx_s] <= merged_line_s;
    end
  end

  // Response, metadata strobes and memory request decode
  always_comb begin
    resp          = blk_valid_r && ((state_r == ST_HIT) || (state_r == ST_MRESP));
    rdata         = resp ? cur_word_s : 32'd0;
    upd_index     = resp ? idx_s : '0;
    upd_way       = resp ? acc_way_s : 1'b0;
    upd_lru_en    = resp;
    upd_lru       = resp ? ~acc_way_s : 1'b0;
    upd_line_en   = resp && (state_r == ST_MRESP);
    upd_tag       = upd_line_en ? tag_s : '0;
    upd_dirty     = upd_line_en && write_r;
    upd_dirty_set = resp && (state_r == ST_HIT) && write_r;
    pmem_read     = (state_r == ST_FILL);
    pmem_write    = (state_r == ST_WB);
    if (state_r == ST_WB) begin
      pmem_address = {victim_tag_r, idx_s, {s_offset{1'b0}}};
      pmem_wdata   = cur_line_s;
    end else if (state_r == ST_FILL) begin
      pmem_address = {tag_s, idx_s, {s_offset{1'b0}}};
      pmem_wdata   = '0;
    end else begin
      pmem_address = 32'd0;
      pmem_wdata   = '0;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;
  logic        miss_start_s;

  // A miss is counted once, when it leaves IDLE/HIT for WB or FILL.
  assign miss_start_s = accept_s && !in_hit;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if ((state_r == ST_HIT) && (hit_cnt_r != 32'hFFFF_FFFF)) hit_cnt_r <= hit_cnt_r + 32'd1;
      if (miss_start_s && (miss_cnt_r != 32'hFFFF_FFFF)) miss_cnt_r <= miss_cnt_r + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_memory_dcache.sv
// tb_memory_dcache: directed bench for memory_dcache with an rdata scoreboard.
// Expected load data is queued when a request is driven and compared when
// the DUT pulses resp.
module tb_memory_dcache;
  localparam int S_TAG  = 24;
  localparam int S_IDX  = 3;
  localparam int S_LINE = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid, in_read, in_write, in_hit, in_way, in_lru, in_dirty;
  logic [31:0]       in_addr, in_wdata;
  logic [3:0]        in_mbe;
  logic [S_TAG-1:0]  in_victim_tag;
  logic              stall, resp, upd_way, upd_lru_en, upd_lru, upd_line_en, upd_dirty, upd_dirty_set;
  logic [31:0]       rdata, pmem_address, hit_count, miss_count;
  logic [S_IDX-1:0]  upd_index;
  logic [S_TAG-1:0]  upd_tag;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [S_LINE-1:0] pmem_wdata, pmem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [S_LINE-1:0] line_a, line_a_mod, line_b, line_c, line_d;

  memory_dcache dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr),
    .in_read(in_read), .in_write(in_write), .in_wdata(in_wdata), .in_mbe(in_mbe),
    .in_hit(in_hit), .in_way(in_way), .in_lru(in_lru), .in_dirty(in_dirty),
    .in_victim_tag(in_victim_tag), .stall(stall), .resp(resp), .rdata(rdata),
    .upd_index(upd_index), .upd_way(upd_way), .upd_lru_en(upd_lru_en), .upd_lru(upd_lru),
    .upd_line_en(upd_line_en), .upd_tag(upd_tag), .upd_dirty(upd_dirty),
    .upd_dirty_set(upd_dirty_set), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [S_LINE-1:0] mk_line(input logic [31:0] base);
    logic [S_LINE-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base | i;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge, check exclusivity and scoreboard.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (pmem_read === 1'b1 || pmem_write === 1'b1) chk("pmem_excl", pmem_read & pmem_write, 0);
    if (resp === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_resp", resp, 0);
      else begin
        e = exp_q.pop_front();
        chk("rdata", rdata, e);
      end
    end
  endtask

  task automatic req(input logic [31:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] be,
                     input logic hit, input logic way, input logic lru, input logic dirty,
                     input logic [S_TAG-1:0] vt);
    in_valid = 1'b1; in_addr = a; in_read = !wr; in_write = wr; in_wdata = wd; in_mbe = be;
    in_hit = hit; in_way = way; in_lru = lru; in_dirty = dirty; in_victim_tag = vt;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_read = 1'b0; in_write = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_resp"}, resp, 0);
    chk({tag, "_pread"}, pmem_read, 0);
    chk({tag, "_pwrite"}, pmem_write, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_upd"}, {upd_lru_en, upd_line_en, upd_dirty_set, upd_dirty}, 0);
    chk({tag, "_hitcnt"}, hit_count, 0);
    chk({tag, "_misscnt"}, miss_count, 0);
  endtask

  initial begin
    idle();
    in_addr = 32'd0; in_wdata = 32'd0; in_mbe = 4'd0; in_hit = 1'b0; in_way = 1'b0;
    in_lru = 1'b0; in_dirty = 1'b0; in_victim_tag = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    line_a = mk_line(32'h1000_0000);
    line_a[31:0] = 32'hDEAD_BEEF;
    line_a_mod = line_a;
    line_a_mod[31:0] = 32'hDEAD_5678;
    line_b = mk_line(32'hCAFE_0000);
    line_c = mk_line(32'h3300_0000);
    line_d = mk_line(32'h8080_0000);

    // Power-on reset
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk_quiet("rst");
    rst_n = 1'b1;
    tick();

    // Clean read miss, victim way 1, memory answers in the third FILL cycle
    req(32'h0000_0040, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    exp_q.push_back(32'hDEAD_BEEF);
    tick(); idle();
    chk("fill1_stall", stall, 1);
    chk("fill1_pread", pmem_read, 1);
    chk("fill1_pwrite", pmem_write, 0);
    chk("fill1_addr", pmem_address, 32'h0000_0040);
    tick();
    chk("fill2_pread", pmem_read, 1);
    tick();
    chk("fill3_pread", pmem_read, 1);
    chk("fill3_addr", pmem_address, 32'h0000_0040);
    pmem_rdata = line_a; pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0;
    chk("mresp_resp", resp, 1);
    chk("mresp_line_en", upd_line_en, 1);
    chk("mresp_way", upd_way, 1);
    chk("mresp_lru", {upd_lru_en, upd_lru}, 2'b10);
    chk("mresp_index", upd_index, 2);
    chk("mresp_tag", upd_tag, 0);
    chk("mresp_dirty", {upd_dirty, upd_dirty_set}, 0);
    tick();
    chk("idle_stall", stall, 0);
    chk("idle_resp", resp, 0);

    // Write hit then back-to-back read hits on the same line
    req(32'h0000_0040, 1'b1, 32'h1234_5678, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    chk("whit_resp", resp, 1);
    chk("whit_stall", stall, 0);
    chk("whit_dset", upd_dirty_set, 1);
    chk("whit_lru", {upd_lru_en, upd_lru, upd_way}, 3'b101);
    req(32'h0000_0040, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    exp_q.push_back(32'hDEAD_5678);
    tick();
    chk("rhit_resp", resp, 1);
    chk("rhit_stall", stall, 0);
    chk("rhit_dset", upd_dirty_set, 0);
    req(32'h0000_0044, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    exp_q.push_back(32'h1000_0001);
    tick(); idle();
    tick();
    chk("post_hit_resp", resp, 0);

    // Stray pmem_resp while idle
    pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0;
    chk("stray_stall", stall, 0);
    chk("stray_resp", resp, 0);

    // Dirty miss: victim tag 1 at index 2 written back, then refill of tag 2
    req(32'h0000_0240, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000001);
    exp_q.push_back(32'hCAFE_0000);
    tick(); idle();
    chk("wb_pwrite", pmem_write, 1);
    chk("wb_pread", pmem_read, 0);
    chk("wb_addr", pmem_address, 32'h0000_0140);
    chk("wb_data", pmem_wdata, line_a_mod);
    tick();
    chk("wb_hold_addr", pmem_address, 32'h0000_0140);
    pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0;
    chk("wbf_pread", pmem_read, 1);
    chk("wbf_pwrite", pmem_write, 0);
    chk("wbf_addr", pmem_address, 32'h0000_0240);
    pmem_rdata = line_b; pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0;
    chk("wbm_resp", resp, 1);
    chk("wbm_tag", upd_tag, 2);
    chk("wbm_line", {upd_line_en, upd_way, upd_lru}, 3'b110);
    tick();

    // Reset one cycle before the refill would complete
    req(32'h0000_0060, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick(); idle();
    chk("rfill_pread", pmem_read, 1);
    tick();
    pmem_rdata = line_c;
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("postrst_stall", stall, 0);
    chk("postrst_resp", resp, 0);

    // Hits after reset, then a write-allocate miss into way 0
    req(32'h0000_0240, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    exp_q.push_back(32'hCAFE_0000);
    tick();
    req(32'h0000_0244, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    exp_q.push_back(32'hCAFE_0001);
    tick();
    req(32'h0000_0248, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    exp_q.push_back(32'hCAFE_0002);
    tick();
    chk("hit3_stall", stall, 0);
    req(32'h0000_0068, 1'b1, 32'hAABB_CCDD, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    exp_q.push_back(32'h3300_0002);
    tick(); idle();
    chk("wmiss_addr", pmem_address, 32'h0000_0060);
    pmem_rdata = line_c; pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0;
    chk("wmiss_dirty", upd_dirty, 1);
    chk("wmiss_way", {upd_way, upd_lru, upd_index}, {1'b0, 1'b1, 3'd3});
    tick();
    req(32'h0000_0068, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    exp_q.push_back(32'hAABB_CCDD);
    tick();
    req(32'h0000_006C, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    exp_q.push_back(32'h3300_0003);
    tick();
    req(32'h0000_0080, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    exp_q.push_back(32'h8080_0000);
    tick(); idle();
    pmem_rdata = line_d; pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0;
    tick();

`ifdef DCACHE_PERF_CNT_EN
    chk("hit_count", hit_count, 5);
    chk("miss_count", miss_count, 2);
`else
    chk("hit_count", hit_count, 0);
    chk("miss_count", miss_count, 0);
`endif
    chk("pending_resp", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_dcache.md
# memory_dcache

Memory stage of the pipelined data cache, directly downstream of the execute (tag-compare) stage. It consumes the per-request block that stage produces: address, read/write, hit, hit way, LRU victim way, victim dirty. It owns the two-way data arrays, serves hits at one per cycle, and runs the write-back/refill state machine against physical memory on misses. It drives the metadata update strobes back into the execute stage's valid/dirty/tag/LRU arrays.

## Interface
Parameters:
- s_offset, 5, byte-offset bits; line = 2**s_offset bytes
- s_index, 3, set-index bits; num_sets = 2**s_index
- s_tag, 32-s_offset-s_index, tag width
- s_line, 8*2**s_offset, line width in bits

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents a block
- in_addr  in  32  request byte address
- in_read / in_write  in  1  request type, mutually exclusive
- in_wdata  in  32  store data
- in_mbe  in  4  store byte enables
- in_hit  in  1  tag hit in either way
- in_way  in  1  hit way (1 = way 1)
- in_lru  in  1  victim way on miss
- in_dirty  in  1  victim line dirty
- in_victim_tag  in  s_tag  victim line tag
- stall  out  1  upstream must hold its block
- resp  out  1  request complete, one-cycle pulse
- rdata  out  32  load data, valid with resp
- upd_index  out  s_index  set for all update strobes
- upd_way  out  1  way for all update strobes
- upd_lru_en  out  1  write LRU bit upd_lru
- upd_lru  out  1  next victim = ~accessed way
- upd_line_en  out  1  write valid=1, tag=upd_tag, dirty=upd_dirty
- upd_tag  out  s_tag  tag of filled line
- upd_dirty  out  1  dirty value on fill
- upd_dirty_set  out  1  set dirty bit (write hit)
- pmem_read / pmem_write  out  1  memory request
- pmem_address  out  32  line-aligned address
- pmem_wdata  out  s_line  write-back line
- pmem_rdata  in  s_line  refill line
- pmem_resp  in  1  memory done
- hit_count / miss_count  out  32  performance counters

## Operation
- States: IDLE, HIT, WB, FILL, MRESP. A block is accepted when in_valid && !stall. stall = state in {WB, FILL, MRESP}.
- Accept in IDLE or HIT:
  - in_hit=1 → HIT.
  - in_hit=0 and in_dirty=1 → WB.
  - in_hit=0 and in_dirty=0 → FILL.
- No accept → IDLE.
- HIT, using the captured block:
  - resp=1.
  - rdata = word addr[s_offset-1:2] of the hit-way line.
  - Write: merge in_wdata under in_mbe into that word at the clock edge; upd_dirty_set=1.
  - upd_lru_en=1, upd_lru=~way.
  - A new block may be accepted in the same cycle.
- WB:
  - pmem_write=1, pmem_address={victim_tag, index, 0}, pmem_wdata = victim line.
  - On pmem_resp → FILL.
- FILL:
  - pmem_read=1, pmem_address={tag, index, 0}.
  - On pmem_resp, pmem_rdata is written into the victim way → MRESP.
- MRESP:
  - resp=1 with rdata from the filled line. Write-allocate: store merged into the line at this edge.
  - upd_line_en=1, upd_tag=tag, upd_dirty=in_write, upd_lru_en=1, upd_lru=~victim.
  - → IDLE.
- Data arrays are not reset. Metadata lives upstream.
- pmem_read/pmem_write are never asserted together. Address and data are held stable until pmem_resp is sampled high.

## Timing
- Reset values: state IDLE, captured block invalid. stall, resp, all upd_* strobes, pmem_read and pmem_write are 0; rdata 0; counters 0.
- Hit latency: accept at edge N, resp during cycle N+1. Back-to-back hits sustain 1/cycle with no stall.
- Hit after a write to the same word sees the merged data, since the array write commits at the end of the HIT cycle.
- Clean miss: resp one cycle after the pmem_resp edge. Dirty miss adds the full WB handshake first.
- All update strobes are single-cycle, coincident with resp. Upstream arrays commit at the same edge.
- pmem_resp outside WB/FILL is ignored.
- Reset mid-WB/FILL: pmem_read/pmem_write drop asynchronously, the in-flight request is discarded with no resp, and the arrays are left as-is.

## Configuration
- DCACHE_PERF_CNT_EN defined:
  - hit_count increments on each HIT-state cycle.
  - miss_count increments on each transition into WB or FILL.
  - Both are 32-bit saturating at 0xFFFF_FFFF and reset to 0.
- Not defined: hit_count and miss_count are tied to 0 and no counter flops are generated.

## Test plan
- Reset: assert rst_n=0 mid-run → stall=0, resp=0, pmem_read=0, pmem_write=0, all upd_*=0, counters 0.
- Clean read miss: addr 0x0000_0040, in_lru=1; pmem_resp after 3 cycles with word0=0xDEADBEEF → pmem_read held 3 cycles at address 0x0000_0040, then resp with rdata=0xDEADBEEF, upd_line_en=1, upd_way=1, upd_lru=0.
- Write hit then read hit to the same address: in_wdata=0x12345678, in_mbe=0011 over line word 0xDEADBEEF → two consecutive resp cycles with stall=0; second rdata=0xDEAD5678; upd_dirty_set=1 on the first resp only.
- Dirty miss: victim tag 0x00001, index 2 → pmem_write with address 0x0000_0140 and the old line, then pmem_read to the new line, then resp; pmem_read and pmem_write never overlap.
- Reset during FILL, 1 cycle before pmem_resp → no resp, state IDLE; a next read hit completes normally.
- With DCACHE_PERF_CNT_EN defined: 5 hits + 2 misses → hit_count=5, miss_count=2. Without it, both counters read 0.
